// File: rtl/ahb_arbiter_2to1.sv
// Two-master to one-slave AHB-Lite arbiter with round-robin arbitration.
// An address phase that cannot issue at once is held and replayed later.
module ahb_arbiter_2to1 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,

  output logic              s0_hready_resp,
  input  logic              s0_hready,
  output logic              s0_hresp,
  input  logic [W_ADDR-1:0] s0_haddr,
  input  logic              s0_hwrite,
  input  logic [1:0]        s0_htrans,
  input  logic [2:0]        s0_hsize,
  input  logic [2:0]        s0_hburst,
  input  logic [3:0]        s0_hprot,
  input  logic              s0_hmastlock,
  input  logic [W_DATA-1:0] s0_hwdata,
  output logic [W_DATA-1:0] s0_hrdata,

  output logic              s1_hready_resp,
  input  logic              s1_hready,
  output logic              s1_hresp,
  input  logic [W_ADDR-1:0] s1_haddr,
  input  logic              s1_hwrite,
  input  logic [1:0]        s1_htrans,
  input  logic [2:0]        s1_hsize,
  input  logic [2:0]        s1_hburst,
  input  logic [3:0]        s1_hprot,
  input  logic              s1_hmastlock,
  input  logic [W_DATA-1:0] s1_hwdata,
  output logic [W_DATA-1:0] s1_hrdata,

  input  logic              dst_hready_resp,
  output logic              dst_hready,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [3:0]        prot;
  } aph_t;

  aph_t       live_aph [2];
  aph_t       hold_aph [2];
  aph_t       cand_aph [2];
  logic [1:0] live;
  logic [1:0] cand;
  logic [1:0] hold_valid;
  logic [1:0] own;
  logic [1:0] rdy;
  logic       sel;
  logic       issue;
  logic       last_grant;
  logic       dph_valid;
  logic       dph_owner;
  logic       unused_inputs;

  assign live_aph[0] = '{addr: s0_haddr, write: s0_hwrite, size: s0_hsize, prot: s0_hprot};
  assign live_aph[1] = '{addr: s1_haddr, write: s1_hwrite, size: s1_hsize, prot: s1_hprot};

  // Burst type, lock and the SEQ/BUSY distinction are deliberately dropped.
  assign unused_inputs = ^{s0_htrans[0], s0_hburst, s0_hmastlock,
                           s1_htrans[0], s1_hburst, s1_hmastlock};

  // Candidate per port and round-robin selection between them.
  always_comb begin
    live[0] = s0_hready && s0_htrans[1];
    live[1] = s1_hready && s1_htrans[1];
    for (int n = 0; n < 2; n++) begin
      cand[n]     = hold_valid[n] || live[n];
      cand_aph[n] = hold_valid[n] ? hold_aph[n] : live_aph[n];
    end
    if (cand[0] && cand[1]) begin
      sel = ~last_grant;
    end else begin
      sel = cand[1];
    end
    // Reset forces IDLE downstream even while masters keep driving requests.
    issue = !rst && dst_hready_resp && (cand[0] || cand[1]);
  end

  // Downstream address phase: selected candidate, or IDLE with port-0 live fields.
  always_comb begin
    if (issue) begin
      dst_htrans = 2'b10;
      dst_haddr  = cand_aph[sel].addr;
      dst_hwrite = cand_aph[sel].write;
      dst_hsize  = cand_aph[sel].size;
      dst_hprot  = cand_aph[sel].prot;
    end else begin
      dst_htrans = 2'b00;
      dst_haddr  = s0_haddr;
      dst_hwrite = s0_hwrite;
      dst_hsize  = s0_hsize;
      dst_hprot  = s0_hprot;
    end
  end

  assign dst_hready    = dst_hready_resp;
  assign dst_hburst    = 3'b000;
  assign dst_hmastlock = 1'b0;
  assign dst_hwdata    = dph_owner ? s1_hwdata : s0_hwdata;
  assign s0_hrdata     = dst_hrdata;
  assign s1_hrdata     = dst_hrdata;

  assign own[0] = dph_valid && !dph_owner;
  assign own[1] = dph_valid && dph_owner;

  // Upstream ready: data-phase owner tracks downstream, a held port stalls.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      if (own[n]) begin
        rdy[n] = dst_hready_resp;
      end else if (hold_valid[n]) begin
        rdy[n] = 1'b0;
      end else begin
        rdy[n] = 1'b1;
      end
    end
  end

  assign s0_hready_resp = rdy[0];
  assign s1_hready_resp = rdy[1];
  assign s0_hresp       = own[0] && dst_hresp;
  assign s1_hresp       = own[1] && dst_hresp;

  // Hold registers, round-robin pointer and downstream data-phase tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid  <= 2'b00;
      hold_aph[0] <= '0;
      hold_aph[1] <= '0;
      last_grant  <= 1'b1;
      dph_valid   <= 1'b0;
      dph_owner   <= 1'b0;
    end else begin
      if (dst_hready_resp) begin
        dph_valid <= issue;
        dph_owner <= sel;
      end
      if (issue) begin
        last_grant <= sel;
      end
      for (int n = 0; n < 2; n++) begin
        if (issue && (sel == 1'(n))) begin
          hold_valid[n] <= 1'b0;
        end else if (live[n]) begin
          hold_valid[n] <= 1'b1;
          hold_aph[n]   <= live_aph[n];
        end
      end
    end
  end

endmodule
